// File: rtl/handshake_pipe_cfg.sv
// Configurable valid/ready register-slice pipeline: DEPTH cascaded slices of one
// type (valid-patting, ready-patting skid, or two-entry full patting).
module handshake_pipe_cfg #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int MODE   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         master_valid,
  input  logic [DATA_W-1:0]            master_data,
  output logic                         master_ready,
  output logic                         slave_valid,
  output logic [DATA_W-1:0]            slave_data,
  input  logic                         slave_ready,
  output logic [$clog2(2*DEPTH+1)-1:0] occupancy
);

  if (DATA_W < 1 || DATA_W > 1024) begin : g_bad_data_w
    $error("handshake_pipe_cfg: DATA_W out of range 1..1024");
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("handshake_pipe_cfg: DEPTH out of range 1..16");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("handshake_pipe_cfg: MODE must be 0, 1 or 2");
  end

  logic m_fire;
  logic s_fire;

  // Each slice owns its handshake nets; neighbours are reached through the
  // generate scope so the forward valid and backward ready chains stay acyclic.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    logic              in_v;
    logic              in_r;
    logic [DATA_W-1:0] in_d;
    logic              out_v;
    logic              out_r;
    logic [DATA_W-1:0] out_d;

    if (i == 0) begin : g_head
      assign in_v = master_valid;
      assign in_d = master_data;
    end else begin : g_link
      assign in_v = g_slice[i-1].out_v;
      assign in_d = g_slice[i-1].out_d;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign out_r = slave_ready;
    end else begin : g_back
      assign out_r = g_slice[i+1].in_r;
    end

    if (MODE == 0) begin : g_m0
      logic              full;
      logic [DATA_W-1:0] data_q;

      assign in_r  = !full || out_r;
      assign out_v = full;
      assign out_d = data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          full   <= 1'b0;
          data_q <= '0;
        end else if (in_v && in_r) begin
          full   <= 1'b1;
          data_q <= in_d;
        end else if (out_r) begin
          full   <= 1'b0;
        end
      end
    end else if (MODE == 1) begin : g_m1
      logic              skid_full;
      logic [DATA_W-1:0] skid;

      assign in_r  = !skid_full;
      assign out_v = in_v || skid_full;
      assign out_d = skid_full ? skid : in_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_full <= 1'b0;
          skid      <= '0;
        end else if (skid_full) begin
          if (out_r) skid_full <= 1'b0;
        end else if (in_v && !out_r) begin
          skid_full <= 1'b1;
          skid      <= in_d;
        end
      end
    end else begin : g_m2
      typedef enum logic [1:0] {EMPTY, ONE, TWO} slot_state_e;
      slot_state_e       state;
      slot_state_e       state_nxt;
      logic [DATA_W-1:0] head;
      logic [DATA_W-1:0] tail;
      logic              push;
      logic              pop;

      assign push  = in_v && in_r;
      assign pop   = out_v && out_r;
      assign in_r  = (state != TWO);
      assign out_v = (state != EMPTY);
      assign out_d = head;

      always_comb begin
        state_nxt = state;
        case (state)
          EMPTY:   if (push) state_nxt = ONE;
          ONE: begin
            if (push && !pop)      state_nxt = TWO;
            else if (pop && !push) state_nxt = EMPTY;
          end
          TWO:     if (pop) state_nxt = ONE;
          default: state_nxt = EMPTY;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
      end

      // head is always the oldest beat; tail only holds the second one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          head <= '0;
          tail <= '0;
        end else begin
          case (state)
            EMPTY: if (push) head <= in_d;
            ONE: begin
              if (push && pop) head <= in_d;
              else if (push)   tail <= in_d;
            end
            TWO:   if (pop) head <= tail;
            default: ;
          endcase
        end
      end
    end
  end

  assign master_ready = g_slice[0].in_r;
  assign slave_valid  = g_slice[DEPTH-1].out_v;
  assign slave_data   = g_slice[DEPTH-1].out_d;

  assign m_fire = master_valid && master_ready;
  assign s_fire = slave_valid && slave_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (m_fire && !s_fire) begin
      occupancy <= occupancy + 1'b1;
    end else if (s_fire && !m_fire) begin
      occupancy <= occupancy - 1'b1;
    end
  end

endmodule

// File: tb/tb_handshake_pipe_cfg.sv
// Bench for handshake_pipe_cfg: eight MODE/DEPTH instances, each driven by its own
// directed + random handshake sequence and checked against a beat-queue model.
module tb_handshake_pipe_cfg;

  localparam int DW   = 16;
  localparam int NCFG = 8;

  function automatic int cfg_mode(input int i);
    return (i < 2) ? 0 : (i < 4) ? 1 : 2;
  endfunction

  function automatic int cfg_depth(input int i);
    case (i)
      0, 2, 4: return 1;
      1, 3, 7: return 4;
      5:       return 2;
      default: return 3;
    endcase
  endfunction

  logic clk;
  int   n_checks;
  int   n_pass;
  int   n_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int M   = cfg_mode(g);
    localparam int D   = cfg_depth(g);
    localparam int CAP = (M == 2) ? 2 * D : D;
    localparam int LAT = (M == 1) ? 0 : D;
    localparam int OW  = $clog2(2 * D + 1);
    localparam int RST_FILL = (CAP < 3) ? CAP : 3;

    logic          rst_n;
    logic          mv;
    logic          mr;
    logic          sv;
    logic          sr;
    logic [DW-1:0] md;
    logic [DW-1:0] sd;
    logic [OW-1:0] occ;

    handshake_pipe_cfg #(
      .DATA_W(DW),
      .DEPTH (D),
      .MODE  (M)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .master_valid(mv),
      .master_data (md),
      .master_ready(mr),
      .slave_valid (sv),
      .slave_data  (sd),
      .slave_ready (sr),
      .occupancy   (occ)
    );

    // Reference: beats accepted but not yet delivered, oldest first.
    logic [DW-1:0] q [$];
    bit            pend;
    logic [DW-1:0] cur;
    bit            prev_hold;
    logic [DW-1:0] prev_sd;
    int            n_in;
    int            n_out;
    bit            sv_s;
    bit            mr_s;
    string         tg;

    task automatic cyc(input bit offer, input bit sr_i);
      if (!pend && offer) begin
        pend = 1'b1;
        cur  = DW'($urandom);
      end
      mv = pend;
      md = cur;
      sr = sr_i;
      #2;
      sv_s = sv;
      mr_s = mr;
      check({tg, "occ"}, 32'(occ), 32'(q.size()));
      if (q.size() == 0) check({tg, "rdy_empty"}, 32'(mr), 32'd1);
      if (q.size() == CAP) check({tg, "rdy_full"}, 32'(mr), (M == 0) ? 32'(sr) : 32'd0);
      if (q.size() == 0 && M != 1) check({tg, "vld_empty"}, 32'(sv), 32'd0);
      if (prev_hold) begin
        check({tg, "hold_vld"}, 32'(sv), 32'd1);
        check({tg, "hold_data"}, 32'(sd), 32'(prev_sd));
      end
      if (mv && mr) begin
        q.push_back(md);
        pend = 1'b0;
        n_in++;
      end
      if (sv && sr) begin
        check({tg, "deliv_has_beat"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check({tg, "data"}, 32'(sd), 32'(q.pop_front()));
        n_out++;
      end
      prev_hold = sv && !sr;
      prev_sd   = sd;
      @(posedge clk);
      #1;
    endtask

    task automatic drain();
      for (int t = 0; t < 2 * CAP + 8; t++) cyc(1'b0, 1'b1);
      check({tg, "drain"}, 32'(n_out), 32'(n_in));
    endtask

    task automatic random_run(input int beats);
      int start;
      int cycles;
      start  = n_out;
      cycles = 0;
      while (n_out - start < beats && cycles < 8000) begin
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        cycles++;
      end
      check({tg, "rand_timeout"}, 32'(n_out - start >= beats), 32'd1);
      drain();
    endtask

    initial begin
      tg        = $sformatf("m%0dd%0d_", M, D);
      rst_n     = 1'b0;
      mv        = 1'b0;
      md        = '0;
      sr        = 1'b0;
      pend      = 1'b0;
      prev_hold = 1'b0;
      n_in      = 0;
      n_out     = 0;
      #3;
      check({tg, "rst_vld"}, 32'(sv), 32'd0);
      check({tg, "rst_data"}, 32'(sd), 32'd0);
      check({tg, "rst_occ"}, 32'(occ), 32'd0);
      check({tg, "rst_rdy"}, 32'(mr), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // continuous stream: first beat appears LAT cycles after its acceptance
      for (int t = 0; t < 12; t++) begin
        cyc(1'b1, 1'b1);
        check({tg, "lat"}, 32'(sv_s), 32'(t >= LAT));
        check({tg, "tput"}, 32'(mr_s), 32'd1);
      end
      drain();

      // backpressure fill, then one cycle with downstream ready while full
      for (int t = 0; t < 2 * CAP + 4; t++) cyc(1'b1, 1'b0);
      check({tg, "fill_cnt"}, 32'(q.size()), 32'(CAP));
      check({tg, "fill_rdy"}, 32'(mr_s), 32'd0);
      cyc(1'b1, 1'b1);
      check({tg, "full_pass_rdy"}, 32'(mr_s), (M == 0) ? 32'd1 : 32'd0);
      drain();

      random_run(1500);

      // reset with beats in flight discards them
      for (int t = 0; t < 30 && q.size() < RST_FILL; t++) cyc(1'b1, 1'b0);
      check({tg, "pre_rst_occ"}, 32'(occ), 32'(RST_FILL));
      mv    = 1'b0;
      pend  = 1'b0;
      rst_n = 1'b0;
      #1;
      check({tg, "mid_rst_vld"}, 32'(sv), 32'd0);
      check({tg, "mid_rst_occ"}, 32'(occ), 32'd0);
      check({tg, "mid_rst_rdy"}, 32'(mr), 32'd1);
      q.delete();
      prev_hold = 1'b0;
      n_in      = 0;
      n_out     = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      random_run(1500);
      n_done++;
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_done   = 0;
    for (int c = 0; c < 40000 && n_done < NCFG; c++) @(posedge clk);
    #4;
    check("all_done", 32'(n_done), 32'(NCFG));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/handshake_pipe_cfg.md
HANDSHAKE_PIPE_CFG -- requirements
Module: handshake_pipe_cfg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning payload width in bits (legal range 1..1024).
REQ-002 The block SHALL have parameter DEPTH, default 1, meaning number of cascaded register slices (legal range 1..16; 0 is illegal and SHALL fail elaboration).
REQ-003 The block SHALL have parameter MODE, default 2, meaning slice type: 0 = valid patting, 1 = ready patting (skid), 2 = both patting (other values SHALL fail elaboration).
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-006 The block SHALL have port master_valid, input, 1 bit, meaning upstream offers a beat.
REQ-007 The block SHALL have port master_data, input, DATA_W bits, meaning upstream payload.
REQ-008 The block SHALL have port master_ready, output, 1 bit, meaning the block accepts a beat this cycle.
REQ-009 The block SHALL have port slave_valid, output, 1 bit, meaning the block offers a beat downstream.
REQ-010 The block SHALL have port slave_data, output, DATA_W bits, meaning downstream payload.
REQ-011 The block SHALL have port slave_ready, input, 1 bit, meaning downstream accepts a beat.
REQ-012 The block SHALL have port occupancy, output, $clog2(2*DEPTH+1) bits, meaning number of beats currently held inside the block.

Function
REQ-013 A transfer SHALL occur on a port exactly when valid and ready are both 1 at a rising clk edge.
REQ-014 Beats SHALL leave in acceptance order, with no loss, duplication or corruption, for any valid/ready pattern.
REQ-015 The upstream side SHALL hold master_valid and master_data stable while master_valid=1 and master_ready=0; the block SHALL likewise hold slave_valid/slave_data stable while slave_ready=0.
REQ-016 Every slice SHALL sustain one transfer per cycle when both sides are continuously valid/ready.
REQ-017 MODE 0 slice: one data register plus valid flag; in_ready = !full || out_ready (combinational); out_valid and out_data registered; latency 1 cycle; capacity 1.
REQ-018 MODE 1 slice: one skid register; in_ready = !skid_full (registered); out_valid = in_valid || skid_full; out_data = skid_full ? skid : in_data; skid loads when in_valid && in_ready && !out_ready; skid drains when out_ready; latency 0 cycles; capacity 1.
REQ-019 MODE 2 slice: two-entry buffer, states EMPTY, ONE, TWO; in_ready = state != TWO (registered); out_valid = state != EMPTY (registered); EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; TWO->ONE on pop; push+pop in ONE stays ONE; latency 1 cycle; capacity 2.
REQ-020 DEPTH slices SHALL be chained; end-to-end latency SHALL be DEPTH cycles for MODE 0/2 and 0 cycles for MODE 1.
REQ-021 In MODE 2 neither master_ready nor slave_valid/slave_data SHALL have a combinational path from any input; in MODE 0 slave_* SHALL be registered; in MODE 1 master_ready SHALL be registered.
REQ-022 occupancy SHALL equal accepted-minus-delivered beats, updated each cycle; max value DEPTH (MODE 0/1) or 2*DEPTH (MODE 2).
REQ-023 When full, master_ready SHALL be 0 except in MODE 0, where a same-cycle slave transfer SHALL allow acceptance.

Reset
REQ-024 On rst_n=0, all valid flags, slice states (EMPTY) and occupancy SHALL clear immediately, independent of clk; slave_valid=0, slave_data=0.
REQ-025 During and after reset master_ready SHALL be 1 (MODE 0 only while slave_ready or empty, which holds since empty).
REQ-026 Reset asserted mid-transfer SHALL discard all held beats; first beat after release SHALL be the first beat accepted after release.

Verification
REQ-027 MODE 2, DEPTH 3, continuous valid/ready, data 1,2,3... -> slave sees 1 at cycle 3 after first accept, then one beat per cycle.
REQ-028 MODE 2, DEPTH 2, slave_ready=0, push 5 beats -> master_ready falls after 4 accepts, occupancy=4; release ready -> 4 beats out in order.
REQ-029 MODE 1, DEPTH 1, slave_ready toggling 1/0 each cycle, valid held 1 -> zero-cycle pass-through when ready, skid holds beat, no loss.
REQ-030 MODE 0, DEPTH 1, full with slave_ready=1 and master_valid=1 -> master_ready=1, simultaneous push/pop, occupancy stays 1.
REQ-031 Random valid/ready (seeded), 30000 beats, each MODE, DEPTH 1 and 4 -> received sequence equals sent sequence, no timeout.
REQ-032 Assert rst_n=0 with occupancy=3 -> slave_valid=0 and occupancy=0 before next clk edge; post-release beats only are delivered.
